// File: rtl/id_ex_reg_if.sv
// ID/EX pipeline register bundle: ID-stage fields going in, EX-stage fields
// coming out, plus the stall/flush controls and the hazard event counters.
interface id_ex_reg_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 Stall;
  logic                 Flush;
  logic [31:0]          PC_in;
  logic [31:0]          IR_in;
  logic [31:0]          A_in;
  logic [31:0]          B_in;
  logic [31:0]          Imm_in;
  logic [4:0]           WAdr_in;
  logic                 RegWrite_in;
  logic                 MemToReg_in;
  logic                 MemWrite_in;
  logic                 AluSrc_in;
  logic                 Halt_in;
  logic [3:0]           AluOp_in;

  logic [31:0]          PC_out;
  logic [31:0]          IR_out;
  logic [31:0]          A_out;
  logic [31:0]          B_out;
  logic [31:0]          Imm_out;
  logic [4:0]           WAdr_out;
  logic                 RegWrite_out;
  logic                 MemToReg_out;
  logic                 MemWrite_out;
  logic                 AluSrc_out;
  logic                 Halt_out;
  logic [3:0]           AluOp_out;
  logic                 Valid_out;
  logic [CNT_WIDTH-1:0] BubbleCnt;
  logic [CNT_WIDTH-1:0] FlushCnt;

  // ID stage side: drives the fields and controls, observes the EX copy.
  modport master (
    output Stall, Flush, PC_in, IR_in, A_in, B_in, Imm_in, WAdr_in,
           RegWrite_in, MemToReg_in, MemWrite_in, AluSrc_in, Halt_in, AluOp_in,
    input  PC_out, IR_out, A_out, B_out, Imm_out, WAdr_out,
           RegWrite_out, MemToReg_out, MemWrite_out, AluSrc_out, Halt_out,
           AluOp_out, Valid_out, BubbleCnt, FlushCnt
  );

  // Pipeline register side.
  modport slave (
    input  Stall, Flush, PC_in, IR_in, A_in, B_in, Imm_in, WAdr_in,
           RegWrite_in, MemToReg_in, MemWrite_in, AluSrc_in, Halt_in, AluOp_in,
    output PC_out, IR_out, A_out, B_out, Imm_out, WAdr_out,
           RegWrite_out, MemToReg_out, MemWrite_out, AluSrc_out, Halt_out,
           AluOp_out, Valid_out, BubbleCnt, FlushCnt
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register. Flush (branch taken in EX) and Stall (load-use)
// both turn the slot into a nop bubble; PC still follows the ID stage.
// Every output comes straight from a flop so the ID-stage hazard logic that
// reads RegWrite_out/WAdr_out sees no combinational loop.
module id_ex_reg #(
  parameter int          CNT_WIDTH = 16,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic         CLK,
  input  logic         RST,
  id_ex_reg_if.slave   bus
);

  // Saturating +1: the counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] r;
    if (v == {CNT_WIDTH{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  logic [31:0]          pc_q, pc_d;
  logic [31:0]          ir_q, ir_d;
  logic [31:0]          a_q, a_d;
  logic [31:0]          b_q, b_d;
  logic [31:0]          imm_q, imm_d;
  logic [4:0]           wadr_q, wadr_d;
  logic                 regwrite_q, regwrite_d;
  logic                 memtoreg_q, memtoreg_d;
  logic                 memwrite_q, memwrite_d;
  logic                 alusrc_q, alusrc_d;
  logic                 halt_q, halt_d;
  logic [3:0]           aluop_q, aluop_d;
  logic                 valid_q, valid_d;
  logic [CNT_WIDTH-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic                 kill_s;

  assign kill_s = bus.Flush | bus.Stall;

  // Next-state for the pipeline slot: either a straight copy or a nop bubble.
  always_comb begin
    pc_d       = bus.PC_in;
    ir_d       = bus.IR_in;
    a_d        = bus.A_in;
    b_d        = bus.B_in;
    imm_d      = bus.Imm_in;
    wadr_d     = bus.WAdr_in;
    regwrite_d = bus.RegWrite_in;
    memtoreg_d = bus.MemToReg_in;
    memwrite_d = bus.MemWrite_in;
    alusrc_d   = bus.AluSrc_in;
    halt_d     = bus.Halt_in;
    aluop_d    = bus.AluOp_in;
    valid_d    = 1'b1;
    if (kill_s) begin
      ir_d       = 32'h0000_0000;
      a_d        = 32'h0000_0000;
      b_d        = 32'h0000_0000;
      imm_d      = 32'h0000_0000;
      wadr_d     = 5'd0;
      regwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      memwrite_d = 1'b0;
      alusrc_d   = 1'b0;
      halt_d     = 1'b0;
      aluop_d    = 4'h0;
      valid_d    = 1'b0;
    end else begin
      valid_d    = 1'b1;
    end
  end

  // Event counters: Flush takes precedence, so a stall+flush cycle counts once as a flush.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (bus.Flush) begin
      flush_cnt_d = sat_inc(flush_cnt_q);
    end else if (bus.Stall) begin
      bubble_cnt_d = sat_inc(bubble_cnt_q);
    end else begin
      bubble_cnt_d = bubble_cnt_q;
      flush_cnt_d  = flush_cnt_q;
    end
  end

  // Slot and counter state; reset clears immediately, independent of CLK.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q         <= RESET_PC;
      ir_q         <= 32'h0000_0000;
      a_q          <= 32'h0000_0000;
      b_q          <= 32'h0000_0000;
      imm_q        <= 32'h0000_0000;
      wadr_q       <= 5'd0;
      regwrite_q   <= 1'b0;
      memtoreg_q   <= 1'b0;
      memwrite_q   <= 1'b0;
      alusrc_q     <= 1'b0;
      halt_q       <= 1'b0;
      aluop_q      <= 4'h0;
      valid_q      <= 1'b0;
      bubble_cnt_q <= {CNT_WIDTH{1'b0}};
      flush_cnt_q  <= {CNT_WIDTH{1'b0}};
    end else begin
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      a_q          <= a_d;
      b_q          <= b_d;
      imm_q        <= imm_d;
      wadr_q       <= wadr_d;
      regwrite_q   <= regwrite_d;
      memtoreg_q   <= memtoreg_d;
      memwrite_q   <= memwrite_d;
      alusrc_q     <= alusrc_d;
      halt_q       <= halt_d;
      aluop_q      <= aluop_d;
      valid_q      <= valid_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bus.PC_out       = pc_q;
  assign bus.IR_out       = ir_q;
  assign bus.A_out        = a_q;
  assign bus.B_out        = b_q;
  assign bus.Imm_out      = imm_q;
  assign bus.WAdr_out     = wadr_q;
  assign bus.RegWrite_out = regwrite_q;
  assign bus.MemToReg_out = memtoreg_q;
  assign bus.MemWrite_out = memwrite_q;
  assign bus.AluSrc_out   = alusrc_q;
  assign bus.Halt_out     = halt_q;
  assign bus.AluOp_out    = aluop_q;
  assign bus.Valid_out    = valid_q;
  assign bus.BubbleCnt    = bubble_cnt_q;
  assign bus.FlushCnt     = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg (4-bit counters so saturation is reachable).
module tb_id_ex_reg;
  localparam int          CW  = 4;
  localparam logic [31:0] RPC = 32'h0000_1000;

  logic CLK;
  logic RST;
  int   n_cmp;
  int   n_err;

  id_ex_reg_if #(.CNT_WIDTH(CW)) bus ();

  id_ex_reg #(.CNT_WIDTH(CW), .RESET_PC(RPC)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic expect_all(input string step,
                            input logic [31:0] pc, input logic [31:0] ir,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] imm, input logic [4:0] wadr,
                            input logic rw, input logic m2r, input logic mw,
                            input logic as, input logic hlt, input logic [3:0] op,
                            input logic vld, input logic [CW-1:0] bc,
                            input logic [CW-1:0] fc);
    chk({step, ".PC"},       bus.PC_out, pc);
    chk({step, ".IR"},       bus.IR_out, ir);
    chk({step, ".A"},        bus.A_out, a);
    chk({step, ".B"},        bus.B_out, b);
    chk({step, ".Imm"},      bus.Imm_out, imm);
    chk({step, ".WAdr"},     32'(bus.WAdr_out), 32'(wadr));
    chk({step, ".RegWrite"}, 32'(bus.RegWrite_out), 32'(rw));
    chk({step, ".MemToReg"}, 32'(bus.MemToReg_out), 32'(m2r));
    chk({step, ".MemWrite"}, 32'(bus.MemWrite_out), 32'(mw));
    chk({step, ".AluSrc"},   32'(bus.AluSrc_out), 32'(as));
    chk({step, ".Halt"},     32'(bus.Halt_out), 32'(hlt));
    chk({step, ".AluOp"},    32'(bus.AluOp_out), 32'(op));
    chk({step, ".Valid"},    32'(bus.Valid_out), 32'(vld));
    chk({step, ".BubbleCnt"}, 32'(bus.BubbleCnt), 32'(bc));
    chk({step, ".FlushCnt"},  32'(bus.FlushCnt), 32'(fc));
  endtask

  task automatic drive(input logic stall, input logic flush,
                       input logic [31:0] pc, input logic [31:0] ir,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [4:0] wadr,
                       input logic rw, input logic m2r, input logic mw,
                       input logic as, input logic hlt, input logic [3:0] op);
    bus.Stall = stall;       bus.Flush = flush;
    bus.PC_in = pc;          bus.IR_in = ir;
    bus.A_in = a;            bus.B_in = b;
    bus.Imm_in = imm;        bus.WAdr_in = wadr;
    bus.RegWrite_in = rw;    bus.MemToReg_in = m2r;
    bus.MemWrite_in = mw;    bus.AluSrc_in = as;
    bus.Halt_in = hlt;       bus.AluOp_in = op;
  endtask

  // One active edge, then settle on the falling edge for sampling/driving.
  task automatic cycle();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    RST = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0,
          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    #2;
    expect_all("reset", RPC, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0);

    // Still in reset across an edge with live inputs.
    drive(1'b0, 1'b0, 32'h0000_0100, 32'h8C22_0004, 32'h1111_1111, 32'h2222_2222,
          32'h0000_0004, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h2);
    cycle();
    chk("reset_hold.IR", bus.IR_out, 32'h0);
    chk("reset_hold.PC", bus.PC_out, RPC);
    RST = 1'b0;

    // Normal flow: lw instruction.
    cycle();
    expect_all("normal", 32'h0000_0100, 32'h8C22_0004, 32'h1111_1111, 32'h2222_2222,
               32'h0000_0004, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h2, 1'b1, 4'h0, 4'h0);

    // Load-use stall: bubble, PC follows.
    drive(1'b1, 1'b0, 32'h0000_0104, 32'h0043_0820, 32'h3333_3333, 32'h4444_4444,
          32'h0000_0820, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5);
    cycle();
    expect_all("stall", 32'h0000_0104, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h1, 4'h0);

    // Stall released: same instruction loads.
    bus.Stall = 1'b0;
    cycle();
    expect_all("after_stall", 32'h0000_0104, 32'h0043_0820, 32'h3333_3333, 32'h4444_4444,
               32'h0000_0820, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 1'b1, 4'h1, 4'h0);

    // Flush alone, with store/halt bits set on input.
    drive(1'b0, 1'b1, 32'h0000_0108, 32'hAC45_0008, 32'h5555_5555, 32'h6666_6666,
          32'h0000_0008, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h3);
    cycle();
    expect_all("flush", 32'h0000_0108, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h1, 4'h1);

    // Stall and Flush together: only FlushCnt moves.
    bus.Stall = 1'b1;
    bus.PC_in = 32'h0000_010C;
    cycle();
    expect_all("stall_flush", 32'h0000_010C, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h1, 4'h2);

    // Normal load carrying MemWrite/Halt.
    drive(1'b0, 1'b0, 32'h0000_0110, 32'hFC00_0000, 32'h7777_7777, 32'h8888_8888,
          32'hFFFF_FFF0, 5'd31, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF);
    cycle();
    expect_all("normal2", 32'h0000_0110, 32'hFC00_0000, 32'h7777_7777, 32'h8888_8888,
               32'hFFFF_FFF0, 5'd31, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 4'h1, 4'h2);

    // Asynchronous reset mid-cycle, checked before the next edge.
    RST = 1'b1;
    #1;
    expect_all("async_rst", RPC, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0);
    #1;
    RST = 1'b0;
    drive(1'b0, 1'b0, 32'h0000_0200, 32'h2001_0005, 32'h0000_0001, 32'h0000_0002,
          32'h0000_0005, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h1);
    cycle();
    expect_all("first_after_rst", 32'h0000_0200, 32'h2001_0005, 32'h0000_0001, 32'h0000_0002,
               32'h0000_0005, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h1, 1'b1, 4'h0, 4'h0);

    // Alternating Stall 1/0 over six cycles.
    for (int i = 0; i < 6; i++) begin
      bus.Stall = (i % 2 == 0) ? 1'b1 : 1'b0;
      cycle();
      chk($sformatf("alt%0d.Valid", i), 32'(bus.Valid_out), (i % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("alt%0d.RegWrite", i), 32'(bus.RegWrite_out), (i % 2 == 0) ? 32'd0 : 32'd1);
    end
    chk("alt.BubbleCnt", 32'(bus.BubbleCnt), 32'd3);
    chk("alt.FlushCnt", 32'(bus.FlushCnt), 32'd0);

    // Saturation: 20 more stalls drive BubbleCnt to all-ones and hold.
    bus.Stall = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk($sformatf("sat%0d.BubbleCnt", i), 32'(bus.BubbleCnt),
          (i + 4 >= 15) ? 32'd15 : 32'(i + 4));
      chk($sformatf("sat%0d.Valid", i), 32'(bus.Valid_out), 32'd0);
    end
    bus.Stall = 1'b0;
    cycle();
    chk("sat_release.BubbleCnt", 32'(bus.BubbleCnt), 32'd15);
    chk("sat_release.Valid", 32'(bus.Valid_out), 32'd1);
    chk("sat_release.IR", bus.IR_out, 32'h2001_0005);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog in case the run stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
